popcount08_unary_gen: RTL and testbench

- Inverse-direction companion to the 8-input popcount blocks. Accepts a count value 0..8 and emits an 8-beat serial thermometer (unary) frame containing exactly that many ones.
- Also presents the equivalent 8-bit parallel word, so a popcount08 instance fed from it must return the original count.
- Used on-sensor to regenerate activation vectors from counts.
- Used in test infrastructure as a stimulus source for exact and approximate popcount circuits.

---
 rtl/popcount08_unary_gen_if.sv | 30 +++
 rtl/popcount08_unary_gen.sv | 133 +++++++++++++
 tb/tb_popcount08_unary_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/popcount08_unary_gen_if.sv
// Handshake bundle for the count-to-thermometer generator: count input,
// serial beat output, parallel word output and status flags.
interface popcount08_unary_gen_if #(
    parameter int N_BITS = 8,
    parameter int CW     = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [CW-1:0]     in_count;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic              out_last;
    logic              word_valid;
    logic [N_BITS-1:0] out_word;
    logic              sat_err;
    logic              busy;

    modport master (
        output in_valid, in_count, out_ready,
        input  in_ready, out_valid, out_bit, out_last,
               word_valid, out_word, sat_err, busy
    );

    modport slave (
        input  in_valid, in_count, out_ready,
        output in_ready, out_valid, out_bit, out_last,
               word_valid, out_word, sat_err, busy
    );
endinterface

// File: rtl/popcount08_unary_gen.sv
// Count-to-unary generator: turns a count 0..N_BITS into an N_BITS-beat
// thermometer frame (ones first) and the matching parallel word.
module popcount08_unary_gen #(
    parameter int N_BITS = 8,
    parameter int CW     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    popcount08_unary_gen_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAX_COUNT = CW'(N_BITS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_BITS - 1);

    // Counts above the frame length clamp to an all-ones frame.
    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

    function automatic logic is_over(input logic [CW-1:0] c);
        return (c > MAX_COUNT);
    endfunction

    state_t            state_q,     state_d;
    logic [CW-1:0]     beat_q,      beat_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [N_BITS-1:0] word_q,      word_d;
    logic              sat_q,       sat_d;
    logic              wv_q,        wv_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_bit_q,   out_bit_d;
    logic              out_last_q,  out_last_d;
    logic              busy_q,      busy_d;

    logic              in_hs;
    logic              out_hs;

    assign in_hs  = bus.in_valid  & in_ready_q;
    assign out_hs = out_valid_q   & bus.out_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sat_d   = sat_q;
        wv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    cnt_d   = sat_count(bus.in_count);
                    sat_d   = sat_q | is_over(bus.in_count);
                    beat_d  = '0;
                    word_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    for (int i = 0; i < N_BITS; i++) begin
                        if (beat_q == CW'(i)) begin
                            word_d[i] = out_bit_q;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        wv_d    = 1'b1;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe and stay stable while the sink stalls.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == SEND);
        out_bit_d   = (state_d == SEND) && (beat_d < cnt_d);
        out_last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            sat_q       <= 1'b0;
            wv_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            sat_q       <= sat_d;
            wv_q        <= wv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bit    = out_bit_q;
    assign bus.out_last   = out_last_q;
    assign bus.word_valid = wv_q;
    assign bus.out_word   = word_q;
    assign bus.sat_err    = sat_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_popcount08_unary_gen.sv
// Scoreboard bench for popcount08_unary_gen: the driver queues expected beats
// and words from a count-level model, an independent monitor checks them.
module tb_popcount08_unary_gen;

    localparam int N  = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    popcount08_unary_gen_if #(.N_BITS(N), .CW(CW)) bus ();

    popcount08_unary_gen #(.N_BITS(N), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit b;
        bit last;
    } beat_exp_t;

    typedef struct {
        logic [N-1:0] word;
        bit           sat;
    } word_exp_t;

    beat_exp_t beat_q_exp[$];
    word_exp_t word_q_exp[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit model_sat = 1'b0;
    int rdy_mode  = 0;
    int rdy_phase = 0;

    bit   prev_stall = 1'b0;
    logic prev_bit   = 1'b0;
    logic prev_last  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: k = min(c, N) ones at the front, word = 2^k - 1.
    task automatic push_frame(input int c);
        int k;
        longint unsigned w;
        word_exp_t we;
        k = (c > N) ? N : c;
        for (int i = 0; i < N; i++) begin
            beat_exp_t be;
            be.b    = (i < k);
            be.last = (i == N - 1);
            beat_q_exp.push_back(be);
        end
        w = (64'd1 << k) - 64'd1;
        model_sat = model_sat | (c > N);
        we.word = w[N-1:0];
        we.sat  = model_sat;
        word_q_exp.push_back(we);
    endtask

    task automatic send(input int c, input bit keep, input bit expect_wv);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_count = CW'(c);
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                if (expect_wv) check("b2b_hs_in_word_valid_cycle", {31'd0, bus.word_valid}, 32'd1);
                push_frame(c);
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd1, 32'd0);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((beat_q_exp.size() != 0 || word_q_exp.size() != 0) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   {31'd0, bus.in_ready},   32'd0);
        check({tag, "_out_valid"},  {31'd0, bus.out_valid},  32'd0);
        check({tag, "_out_bit"},    {31'd0, bus.out_bit},    32'd0);
        check({tag, "_out_last"},   {31'd0, bus.out_last},   32'd0);
        check({tag, "_word_valid"}, {31'd0, bus.word_valid}, 32'd0);
        check({tag, "_sat_err"},    {31'd0, bus.sat_err},    32'd0);
        check({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
        check({tag, "_out_word"},   {24'd0, bus.out_word},   32'd0);
    endtask

    // out_ready pattern generator
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = (rdy_phase % 3 == 0);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            rdy_phase++;
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    check("in_ready_low_in_frame", {31'd0, bus.in_ready}, 32'd0);
                    check("busy_in_frame",         {31'd0, bus.busy},     32'd1);
                    if (prev_stall) begin
                        check("stall_out_bit_stable",  {31'd0, bus.out_bit},  {31'd0, prev_bit});
                        check("stall_out_last_stable", {31'd0, bus.out_last}, {31'd0, prev_last});
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (beat_q_exp.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        beat_exp_t be;
                        be = beat_q_exp.pop_front();
                        check("out_bit",  {31'd0, bus.out_bit},  {31'd0, be.b});
                        check("out_last", {31'd0, bus.out_last}, {31'd0, be.last});
                    end
                end
                if (bus.word_valid) begin
                    if (word_q_exp.size() == 0) begin
                        check("unexpected_word_valid", 32'd1, 32'd0);
                    end else begin
                        word_exp_t we;
                        we = word_q_exp.pop_front();
                        check("out_word",        {24'd0, bus.out_word}, {24'd0, we.word});
                        check("sat_err_at_word", {31'd0, bus.sat_err},  {31'd0, we.sat});
                        check("beats_before_word", beat_q_exp.size(), 32'd0);
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_bit   = bus.out_bit;
                prev_last  = bus.out_last;
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_count = '0;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        rdy_mode = 0;
        send(3, 1'b0, 1'b0);
        drain();
        check("sat_err_after_3", {31'd0, bus.sat_err}, 32'd0);

        send(0, 1'b0, 1'b0);
        drain();
        send(8, 1'b0, 1'b0);
        drain();

        rdy_mode  = 1;
        rdy_phase = 0;
        send(5, 1'b0, 1'b0);
        drain();
        rdy_mode = 0;

        send(13, 1'b0, 1'b0);
        drain();
        check("sat_err_after_13", {31'd0, bus.sat_err}, 32'd1);
        send(2, 1'b0, 1'b0);
        drain();
        check("sat_err_sticky", {31'd0, bus.sat_err}, 32'd1);

        send(4, 1'b1, 1'b0);
        send(6, 1'b0, 1'b1);
        drain();

        // Abort an in_count=7 frame while beat 4 is on the output.
        send(7, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        beat_q_exp.delete();
        word_q_exp.delete();
        model_sat = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_abort", {31'd0, bus.in_ready}, 32'd1);
        send(1, 1'b0, 1'b0);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            send(int'($urandom_range(0, 15)), 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_at_end", {31'd0, bus.in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
